traffic_input_cond: RTL
=======================

Name: traffic_input_cond

Overview:
- Input-conditioning stage directly upstream of the traffic-light FSM.
- Synchronises the raw pedestrian push-button and vehicle-sensor pins, then debounces them against a prescaled sample tick.
- Produces a latched, held-until-served PB request and a qualified VS presence level that drive the controller's PB and VS inputs.
- Also exports the sample tick so downstream timers can share the same time base.

Parameters:
- CLK_DIV, 50: clk cycles per sample tick; legal range ≥ 1.
- DEB_TICKS, 3: consecutive equal PB samples needed to change the debounced PB state; legal range ≥ 1.
- VS_HOLD, 2: consecutive high VS samples needed to assert VS; legal range ≥ 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- pb_raw, input, 1: raw pedestrian button, asynchronous, active-high.
- vs_raw, input, 1: raw side-road vehicle sensor, asynchronous, active-high.
- walk, input, 1: walk indication fed back from the controller; 0 = walk green, 1 = walk red.
- tick, output, 1: one-cycle sample strobe.
- PB, output, 1: latched pedestrian request to the controller.
- VS, output, 1: qualified vehicle presence to the controller.
- pb_db, output, 1: debounced button level, exported for debug.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0. This covers tick, PB, VS and pb_db. The synchroniser flops, prescaler, debounce counters and VS hold counter also clear to 0.
- Reset released mid-operation: everything restarts from the reset state. No partially counted debounce or hold survives.
- Synchroniser: pb_raw and vs_raw each pass through two flops. The synchronised copies, pb_s and vs_s, lag the pins by 2 clk.
- Prescaler: the counter runs 0..CLK_DIV-1 and wraps to 0.
  - tick=1 for exactly one cycle when the counter equals CLK_DIV-1.
  - With CLK_DIV=1, tick is held high every cycle.
  - The first tick after reset release occurs at clk edge CLK_DIV.
  - Counter width is clog2(CLK_DIV), minimum 1.
- PB debounce (updates only on tick cycles):
  - If pb_s equals pb_db, the debounce counter clears.
  - Otherwise the counter increments. When it reaches DEB_TICKS, pb_db toggles and the counter clears.
  - The counter saturates and never wraps. Width is clog2(DEB_TICKS+1).
  - An excursion shorter than DEB_TICKS ticks never changes pb_db.
- PB request latch:
  - Set on the cycle after a 0→1 transition of pb_db.
  - Cleared on the cycle after walk is sampled at 0.
  - Clear has priority over set: if walk=0 in the same cycle as a pb_db rise, PB ends at 0 (a press during walk green counts as served).
  - While walk=0, PB is held at 0.
  - Release of the button never clears PB.
  - Multiple presses while PB=1 have no further effect.
- VS qualification (updates only on tick cycles):
  - If vs_s=1, the hold counter increments, saturating at VS_HOLD. VS=1 once the counter reaches VS_HOLD.
  - If vs_s=0, the hold counter clears and VS=0 on that same tick update. No debounce applies on drop.
- Output timing: all outputs are registered. VS and pb_db change on the clk edge of the qualifying tick. PB follows pb_db one clk later.
- Latency example (CLK_DIV=4, DEB_TICKS=3): pb_raw rising and held changes PB after ≤ 2 + 3·4 + 1 clk, i.e. 15 clk worst case.

Test Plan (CLK_DIV=4, DEB_TICKS=3, VS_HOLD=2):
- Reset:
  - Stimulus: hold rst=0 for 3 clk, then release.
  - Required response: all outputs 0 during reset; tick=1 at clk edges 4, 8, 12 after release, and 0 otherwise.
- Glitch rejection:
  - Stimulus: pb_raw=1 spanning exactly 2 ticks, then 0.
  - Required response: pb_db and PB stay 0 throughout.
- Press and serve:
  - Stimulus: pb_raw=1 held 5 ticks, then released; walk=1 for 10 ticks, then walk=0 for 1 cycle.
  - Required response: pb_db=1 at the 3rd tick; PB=1 one clk later; PB stays 1 after release and after pb_db returns to 0; PB=0 the clk after walk=0.
- Press during walk:
  - Stimulus: walk=0 held; pb_raw=1 for 5 ticks.
  - Required response: pb_db rises, PB stays 0. Then set walk=1 with the button still held: PB stays 0 (no new edge).
- VS qualification:
  - Stimulus: vs_raw=1 for 1 tick, then vs_raw=1 for 3 ticks, then vs_raw=0.
  - Required response: VS stays 0 during the single tick; VS=1 at the 2nd tick of the second window; VS=0 at the first tick sampling 0.
- Mid-operation reset:
  - Stimulus: assert rst=0 while the PB debounce count is 2 and PB=1; release rst.
  - Required response: all outputs 0 immediately. A subsequent 2-tick press does not set pb_db; a full 3-tick debounce from zero is needed.

Source files
------------

// File: rtl/traffic_input_cond.sv
// traffic_input_cond
// Input-conditioning stage in front of the traffic-light controller.
// The raw push-button and vehicle-sensor pins are synchronised. They are
// then qualified against a shared prescaled sample tick:
//   - the push-button is debounced, and a request is latched that stays
//     set until the controller serves it;
//   - the vehicle sensor must be high for several ticks before presence
//     is reported, and presence drops on the first low sample.
// The sample tick is exported so that downstream timers run on the same
// time base.

module traffic_input_cond #(
    parameter int CLK_DIV   = 50,
    parameter int DEB_TICKS = 3,
    parameter int VS_HOLD   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_raw,
    input  logic vs_raw,
    input  logic walk,
    output logic tick,
    output logic PB,
    output logic VS,
    output logic pb_db
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(VS_HOLD + 1);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(VS_HOLD);

    logic          pb_m;
    logic          pb_s;
    logic          vs_m;
    logic          vs_s;
    logic [CW-1:0] div_cnt;
    logic          tick_now;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_inc;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_inc;
    logic          pb_db_q;
    logic          pb_rise;

    // Qualifying updates happen on the same edge that raises the registered
    // tick. As a result, pb_db and VS change together with tick.
    assign tick_now = (div_cnt == DIV_LAST);
    assign deb_inc  = deb_cnt + 1'b1;
    assign hold_inc = hold_cnt + 1'b1;
    assign pb_rise  = pb_db & ~pb_db_q;

    // Two-flop synchronisers for the asynchronous pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb_m <= 1'b0;
            pb_s <= 1'b0;
            vs_m <= 1'b0;
            vs_s <= 1'b0;
        end else begin
            pb_m <= pb_raw;
            pb_s <= pb_m;
            vs_m <= vs_raw;
            vs_s <= vs_m;
        end
    end

    // Prescaler: counts 0..CLK_DIV-1 and strobes tick on the wrap.
    // With CLK_DIV=1 the counter is always at its last value, so tick
    // stays high on every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= tick_now;
            if (tick_now) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Push-button debounce: the state flips only after DEB_TICKS
    // consecutive disagreeing samples. Any sample that agrees with the
    // current state restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt <= '0;
            pb_db   <= 1'b0;
        end else if (tick_now) begin
            if (pb_s == pb_db) begin
                deb_cnt <= '0;
            end else if (deb_inc == DEB_LAST) begin
                pb_db   <= ~pb_db;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_inc;
            end
        end
    end

    // Pedestrian request latch. It is set by a rising edge of the debounced
    // button and cleared while walk is green. Clear wins over set, so a
    // press made during walk green counts as already served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb_db_q <= 1'b0;
            PB      <= 1'b0;
        end else begin
            pb_db_q <= pb_db;
            if (!walk) begin
                PB <= 1'b0;
            end else if (pb_rise) begin
                PB <= 1'b1;
            end
        end
    end

    // Vehicle presence: VS asserts after VS_HOLD consecutive high samples.
    // It drops on the first low sample, with no hysteresis on the drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            VS       <= 1'b0;
        end else if (tick_now) begin
            if (vs_s) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_inc;
                end
                VS <= (hold_cnt == HOLD_MAX) || (hold_inc == HOLD_MAX);
            end else begin
                hold_cnt <= '0;
                VS       <= 1'b0;
            end
        end
    end

endmodule
